// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared types and constants for the rv32i writeback slice.
//               regaddr_t / word_t name the register address and data widths.
//               reg_onehot turns a register address into a 32-bit bitmap mask.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    typedef logic [4:0]  regaddr_t;
    typedef logic [31:0] word_t;

    localparam regaddr_t REG_ZERO = 5'd0;

    // One-hot mask selecting the scoreboard bit of register r.
    function automatic word_t reg_onehot(input regaddr_t r);
        return word_t'(1) << r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_scoreboard
// Description : Register scoreboard. A bit is set when an instruction issues
//               (without hazard) with a nonzero destination, and cleared by the
//               register-file write to that register. Same-edge set and clear
//               of one register resolves to set.
// Ports       : clk, reset (async, active low)
//               issue_valid/issue_rd  - issuing instruction and destination
//               rs1_reg/rs2_reg       - sources of the issuing instruction
//               wb_enable/wb_reg      - register-file write port (clear side)
//               rs1_busy/rs2_busy     - source has a write in flight (comb)
//               hazard                - RAW on either source or WAW on rd
//               pending               - scoreboard bitmap, bit 0 always 0
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_scoreboard
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_reg,
    input  logic [4:0]  rs2_reg,
    input  logic        wb_enable,
    input  logic [4:0]  wb_reg,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        hazard,
    output logic [31:0] pending
);

    word_t r_pending;
    word_t w_set_mask;
    word_t w_clr_mask;
    logic  w_rd_busy;

    // Bit 0 never sets, but the explicit x0 guard keeps busy correct even if
    // the bitmap were ever corrupted.
    assign rs1_busy  = r_pending[rs1_reg]  && (rs1_reg  != REG_ZERO);
    assign rs2_busy  = r_pending[rs2_reg]  && (rs2_reg  != REG_ZERO);
    assign w_rd_busy = r_pending[issue_rd] && (issue_rd != REG_ZERO);
    assign hazard    = rs1_busy || rs2_busy || w_rd_busy;

    assign w_set_mask = (issue_valid && !hazard && (issue_rd != REG_ZERO))
                        ? reg_onehot(issue_rd) : '0;
    assign w_clr_mask = wb_enable ? reg_onehot(wb_reg) : '0;

    // Clear applied before set so a collision on one register leaves it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~word_t'(1);
        end
    end

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/rv32i_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_wb_arbiter
// Description : Writeback arbiter plus register scoreboard. Merges ALU and
//               load writebacks into the single register-file write port.
//               Load has priority unless the ALU has been denied STARVE_LIMIT
//               consecutive cycles, in which case the ALU wins once.
// Parameters  : STARVE_LIMIT - denied ALU cycles before ALU override (1..15)
// Ports       : clk, reset (async, active low)
//               alu_valid/alu_ready/alu_rd/alu_data - ALU writeback request
//               ld_valid/ld_ready/ld_rd/ld_data     - load writeback request
//               wb_enable/wb_reg/wb_data            - registered RF write port
//               issue_valid/issue_rd/rs1_reg/rs2_reg - issue-side lookup
//               rs1_busy/rs2_busy/hazard/pending    - scoreboard status
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        wb_enable,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_reg,
    input  logic [4:0]  rs2_reg,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        hazard,
    output logic [31:0] pending
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       w_alu_priority;
    logic       w_alu_grant;
    logic       w_ld_grant;
    logic       w_grant;
    regaddr_t   w_grant_rd;
    word_t      w_grant_data;

    // ------------------------------------------------------------------
    // Arbitration: purely from valids and starvation state, never from the
    // writeback registers. Reset low masks both grants immediately.
    // ------------------------------------------------------------------
    assign w_alu_priority = (r_starve_cnt == c_starve_limit);
    assign w_ld_grant     = reset && ld_valid && !(alu_valid && w_alu_priority);
    assign w_alu_grant    = reset && alu_valid && !w_ld_grant;
    assign w_grant        = w_alu_grant || w_ld_grant;

    assign alu_ready = w_alu_grant;
    assign ld_ready  = w_ld_grant;

    assign w_grant_rd   = w_ld_grant ? regaddr_t'(ld_rd)  : regaddr_t'(alu_rd);
    assign w_grant_data = w_ld_grant ? word_t'(ld_data)   : word_t'(alu_data);

    // Counts consecutive denied ALU cycles; any ALU grant or idle ALU restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!alu_valid || w_alu_grant) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_starve_limit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Writeback stage. x0 grants still load wb_reg/wb_data but never
    // raise the write enable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_enable <= 1'b0;
            wb_reg    <= REG_ZERO;
            wb_data   <= '0;
        end else begin
            wb_enable <= w_grant && (w_grant_rd != REG_ZERO);
            if (w_grant) begin
                wb_reg  <= w_grant_rd;
                wb_data <= w_grant_data;
            end
        end
    end

    rv32i_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_reg     (rs1_reg),
        .rs2_reg     (rs2_reg),
        .wb_enable   (wb_enable),
        .wb_reg      (wb_reg),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .hazard      (hazard),
        .pending     (pending)
    );

endmodule
`default_nettype wire

// File: tb/tb_rv32i_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_wb_arbiter
// Description : Self-checking bench for rv32i_wb_arbiter (STARVE_LIMIT = 4).
//               A cycle table drives one vector per clock: combinational
//               outputs are compared mid-cycle, registered outputs after the
//               following edge. Reset behaviour is checked by hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic [4:0]  rs1_reg = 5'd0;
    logic [4:0]  rs2_reg = 5'd0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        hazard;
    logic [31:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .wb_enable   (wb_enable),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_reg     (rs1_reg),
        .rs2_reg     (rs2_reg),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .hazard      (hazard),
        .pending     (pending)
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic        iv;  logic [4:0] ird; logic [4:0]  r1; logic [4:0] r2;
        logic        e_ar; logic e_lr; logic e_b1; logic e_b2; logic e_hz;
        logic        e_we; logic [4:0] e_wr; logic [31:0] e_wd; logic [31:0] e_pd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_ar, input logic e_lr, input logic e_b1, input logic e_b2, input logic e_hz,
        input logic e_we, input logic [4:0] e_wr, input logic [31:0] e_wd, input logic [31:0] e_pd);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_hz = e_hz;
        v.e_we = e_we; v.e_wr = e_wr; v.e_wd = e_wd; v.e_pd = e_pd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] ld_val;
        bit          g;

        // ---------------- table construction ----------------
        //        av ard ad            lv lrd ld        iv ird r1 r2  ar lr b1 b2 hz  we wr wd            pd
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h20));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 5, 0, 1, 0, 1, 0, 1, 1, 5, 32'hDEADBEEF, 32'h20));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 5, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 32'h0,  0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h1234,     32'h0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 7, 32'h77, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 7, 32'h77,       32'h0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77,       32'h80));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77,       32'h280));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 0, 0, 0, 0, 0, 0, 1, 0, 7, 32'h77,       32'h280));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 9, 7, 0, 0, 1, 1, 1, 0, 7, 32'h77,       32'h280));
        // Contention: expected grants L,L,L,L,A twice. A load request holds
        // its data until granted, then the next load carries a new value.
        ld_val = 32'h100;
        for (int i = 0; i < 10; i++) begin
            g = ((i % 5) == 4);
            tbl.push_back(mk(1, 1, 32'hA1, 1, 2, ld_val, 0, 0, 0, 0,
                             g, !g, 0, 0, 0, 1, g ? 5'd1 : 5'd2, g ? 32'hA1 : ld_val, 32'h280));
            if (!g) ld_val = ld_val + 32'd1;
        end

        // ---------------- initial reset ----------------
        alu_valid = 1'b1; ld_valid = 1'b1; alu_rd = 5'd1; ld_rd = 5'd2;
        #2 reset = 1'b0;
        #1;
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
        chk("rst_wb_enable", {31'd0, wb_enable}, 32'd0);
        chk("rst_wb_reg",    {27'd0, wb_reg},    32'd0);
        chk("rst_wb_data",   wb_data,            32'd0);
        chk("rst_pending",   pending,            32'd0);
        repeat (2) @(posedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // ---------------- table run ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            ld_valid  = tbl[i].lv; ld_rd  = tbl[i].lrd; ld_data  = tbl[i].ld;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            rs1_reg = tbl[i].r1; rs2_reg = tbl[i].r2;
            #1;
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, tbl[i].e_ar});
            chk($sformatf("v%0d_ld_ready",  i), {31'd0, ld_ready},  {31'd0, tbl[i].e_lr});
            chk($sformatf("v%0d_rs1_busy",  i), {31'd0, rs1_busy},  {31'd0, tbl[i].e_b1});
            chk($sformatf("v%0d_rs2_busy",  i), {31'd0, rs2_busy},  {31'd0, tbl[i].e_b2});
            chk($sformatf("v%0d_hazard",    i), {31'd0, hazard},    {31'd0, tbl[i].e_hz});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_enable", i), {31'd0, wb_enable}, {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d_wb_reg",    i), {27'd0, wb_reg},    {27'd0, tbl[i].e_wr});
            chk($sformatf("v%0d_wb_data",   i), wb_data,            tbl[i].e_wd);
            chk($sformatf("v%0d_pending",   i), pending,            tbl[i].e_pd);
        end

        // ---------------- mid-stream reset ----------------
        issue_valid = 1'b0; issue_rd = 5'd0; rs1_reg = 5'd0; rs2_reg = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h5A5A;
        #1;
        chk("pre_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("mid_rst_ld_ready",  {31'd0, ld_ready},  32'd0);
        chk("mid_rst_wb_enable", {31'd0, wb_enable}, 32'd0);
        chk("mid_rst_wb_reg",    {27'd0, wb_reg},    32'd0);
        chk("mid_rst_pending",   pending,            32'd0);
        @(posedge clk); #1;
        chk("mid_rst_hold_wb_enable", {31'd0, wb_enable}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("post_rst_ld_ready",  {31'd0, ld_ready},  32'd1);
        chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_wb_enable", {31'd0, wb_enable}, 32'd1);
        chk("post_rst_wb_reg",    {27'd0, wb_reg},    32'd2);
        chk("post_rst_wb_data",   wb_data,            32'h5A5A);
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wb_enable", {31'd0, wb_enable}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_wb_arbiter.md
# rv32i_wb_arbiter

Writeback arbiter and register scoreboard for the rv32i core. It merges writeback requests from the ALU pipeline and the load unit into the register file's single write port, one write per cycle, with bounded starvation for the ALU. It also tracks which registers have writes in flight so that issue can stall on RAW and WAW hazards. It sits between execute/memory and the register file; the wb_* outputs drive the register file's write port directly.

## Interface
- STARVE_LIMIT, 4: consecutive denied ALU cycles before the ALU overrides load priority (legal range 1–15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load writeback request.
- ld_ready  out  1  load request granted this cycle.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- wb_enable  out  1  register-file write enable (registered).
- wb_reg  out  5  register-file write address (registered).
- wb_data  out  32  register-file write data (registered).
- issue_valid  in  1  instruction issued this cycle; marks issue_rd pending.
- issue_rd  in  5  destination of the issuing instruction.
- rs1_reg, rs2_reg  in  5 each  sources of the instruction at issue.
- rs1_busy, rs2_busy  out  1 each  source has a write pending (combinational).
- hazard  out  1  rs1_busy | rs2_busy | rd_busy (combinational).
- pending  out  32  scoreboard bitmap; bit 0 is always 0.

## Operation
- **Handshake:** a request transfers when valid && ready at a rising edge. The requester holds rd and data stable until ready. Ready is combinational from the valids and the starvation state, and is forced to 0 while reset is low.
- **Arbitration:**
  - At most one grant per cycle.
  - Load wins over ALU, unless starve_cnt == STARVE_LIMIT, in which case the ALU wins.
  - A lone valid is always granted.
- **starve_cnt** (4-bit):
  - Increments when alu_valid && !alu_ready, saturating at STARVE_LIMIT.
  - Clears on ALU grant or when alu_valid is low.
- **Writeback stage:** on a grant, the next edge registers the granted rd and data into wb_reg and wb_data. wb_enable = 1 if rd != 0, else 0. With no grant, wb_enable = 0 and wb_reg/wb_data hold their values.
- **x0 requests:** accepted normally and consume the grant slot, but produce no write.
- **Scoreboard set:**
  - Condition: issue_valid && !hazard && issue_rd != 0 sets pending[issue_rd].
  - issue_valid while hazard = 1 is ignored and sets nothing.
  - rd_busy = pending[issue_rd].
- **Scoreboard clear:** wb_enable high at an edge clears pending[wb_reg] at that same edge, together with the register-file write.
- **Simultaneous set and clear of the same register:** set wins, and the bit stays 1.
- **busy outputs:** rs*_busy = pending[rs*_reg]. Register 0 always reads not-busy.

## Timing
- **Reset (asynchronous assert):**
  - wb_enable = 0, wb_reg = 0, wb_data = 0, pending = 0, starve_cnt = 0.
  - alu_ready = ld_ready = 0 immediately.
  - In-flight writebacks are dropped.
  - Release is synchronous to the first clk edge after reset goes high.
- **Latency:** grant at edge N → wb_enable high during cycle N+1 → register written and pending bit cleared at edge N+1. A dependent instruction sees busy = 0 in cycle N+1 after edge N+1 and reads the new data.
- **Throughput:** one writeback per cycle sustained. With both requesters continuously valid, the ALU is granted at least once every STARVE_LIMIT+1 cycles.
- **Combinational paths:**
  - valids → readies.
  - rs*/issue_rd → busy/hazard.
  - There is no path from wb_* to readies.

## Structure
- Shared package rv32i_pkg: typedef regaddr_t (logic [4:0]), typedef word_t (logic [31:0]), constant REG_ZERO = 5'd0.
- Sub-module rv32i_scoreboard: contains the pending bitmap, set/clear logic, and busy/hazard outputs.
- The arbiter, starvation counter, and writeback registers live in the top level.

## Test plan
- **Reset:** pulse reset low mid-stream with both valids high → readies 0 immediately, wb_enable 0, pending 0. After release, the load is granted first.
- **Contention:** ld_valid and alu_valid both held high, STARVE_LIMIT = 4 → grant pattern L,L,L,L,A repeating. wb_reg and wb_data follow one cycle later.
- **Scoreboard RAW:**
  - Issue rd = 5 → pending[5] = 1, and rs1_reg = 5 gives hazard = 1.
  - ALU write to x5 with data 0xDEADBEEF granted at edge N → pending[5] = 0 after edge N+1.
- **x0:** alu_rd = 0, data 0x1234 → alu_ready = 1, next cycle wb_enable = 0, pending[0] stays 0.
- **Set/clear collision:** wb_enable for x7 at the same edge as issue_valid with issue_rd = 7 (hazard = 0) → pending[7] remains 1.
- **WAW:** pending[9] = 1, issue_rd = 9 with issue_valid → hazard = 1 and the bitmap is unchanged.
